byte_addressing_v4: RTL and testbench

BYTE_ADDRESSING_V4 -- requirements
Module: byte_addressing_v4

---
 rtl/byte_addressing_v4.sv | 105 ++++++++++
 tb/tb_byte_addressing_v4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_addressing_v4.sv
// ---------------------------------------------------------------------------
// byte_addressing_v4
//   Turns a stream of 32-bit FIFO words into byte-aligned 32-bit windows.
//   A 16-byte in-order buffer is refilled from the FIFO. The consumer can
//   drop 1..7 bytes from the head each cycle.
//
// Ports
//   clk          rising-edge clock for all state
//   rstN         synchronous reset, active-high
//   fifo_data    FIFO word, [31:24] is the earliest stream byte
//   fifo_valid   fifo_data valid this cycle
//   fifo_empty   upstream FIFO has no data
//   rd_fifo_en   read request to the FIFO (one word per asserted cycle)
//   rd_data_en   consumer ready, gates shift acceptance
//   byte4_en     enables fetching from the FIFO
//   byte4_busy   enabled but windows not yet valid
//   byte4_data1..byte4_data4  windows at head offsets 0..3
//   byte4_valid  at least 7 real bytes buffered (all four windows full)
//   shift_dist   bytes to consume (0..7)
//   shift_en     shift request
// ---------------------------------------------------------------------------
module byte_addressing_v4 (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] fifo_data,
    input  logic        fifo_valid,
    input  logic        fifo_empty,
    output logic        rd_fifo_en,
    input  logic        rd_data_en,
    input  logic        byte4_en,
    output logic        byte4_busy,
    output logic [31:0] byte4_data1,
    output logic [31:0] byte4_data2,
    output logic [31:0] byte4_data3,
    output logic [31:0] byte4_data4,
    output logic        byte4_valid,
    input  logic [2:0]  shift_dist,
    input  logic        shift_en
);

    // The buffer is packed with B[0] in the top byte. Bytes at or beyond cnt
    // are kept at zero. A left shift then consumes head bytes, and the
    // incoming word can be ORed in at the tail.
    logic [127:0] byte_buf;
    logic [127:0] buf_shifted;
    logic [127:0] buf_next;
    logic [4:0]   cnt;
    logic [4:0]   cnt_next;
    logic [4:0]   base;
    logic [1:0]   pend;
    logic [1:0]   pend_next;
    logic [5:0]   fill_level;
    logic [2:0]   shift_amt;
    logic         shift_ok;
    logic         append_ok;
    logic         pend_dec;

    assign byte4_valid = (cnt >= 5'd7);
    assign byte4_busy  = byte4_en & ~byte4_valid;

    assign byte4_data1 = byte_buf[127:96];
    assign byte4_data2 = byte_buf[119:88];
    assign byte4_data3 = byte_buf[111:80];
    assign byte4_data4 = byte_buf[103:72];

    // Count words still in flight as already buffered. This stops a request
    // from being issued when its answer could not fit.
    assign fill_level = {1'b0, cnt} + {2'b00, pend, 2'b00};
    assign rd_fifo_en = byte4_en & ~fifo_empty & (fill_level <= 6'd8) & ~rstN;

    // A shift is only accepted while cnt >= 7. shift_dist is at most 7, so
    // base below can never underflow.
    assign shift_ok  = shift_en & rd_data_en & byte4_valid & (shift_dist != 3'd0);
    assign shift_amt = shift_ok ? shift_dist : 3'd0;
    assign base      = cnt - {2'b00, shift_amt};

    // Any returning word is accepted when it fits, solicited or not.
    // A word that would overflow the buffer is dropped.
    assign append_ok = fifo_valid & (base <= 5'd12);
    assign pend_dec  = fifo_valid & (pend != 2'd0);

    always_comb begin
        buf_shifted = byte_buf << {shift_amt, 3'b000};
        buf_next    = buf_shifted;
        cnt_next    = base;
        if (append_ok) begin
            buf_next = buf_shifted | ({fifo_data, 96'd0} >> {base, 3'b000});
            cnt_next = base + 5'd4;
        end
        pend_next = pend + {1'b0, rd_fifo_en} - {1'b0, pend_dec};
    end

    always_ff @(posedge clk) begin
        if (rstN) begin
            byte_buf <= '0;
            cnt      <= '0;
            pend     <= '0;
        end else begin
            byte_buf <= buf_next;
            cnt      <= cnt_next;
            pend     <= pend_next;
        end
    end

endmodule

// File: tb/tb_byte_addressing_v4.sv
module tb_byte_addressing_v4;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_empty;
    logic        rd_fifo_en;
    logic        rd_data_en;
    logic        byte4_en;
    logic        byte4_busy;
    logic [31:0] byte4_data1, byte4_data2, byte4_data3, byte4_data4;
    logic        byte4_valid;
    logic [2:0]  shift_dist;
    logic        shift_en;

    always #5 clk = ~clk;

    byte_addressing_v4 dut (
        .clk         (clk),
        .rstN        (rstN),
        .fifo_data   (fifo_data),
        .fifo_valid  (fifo_valid),
        .fifo_empty  (fifo_empty),
        .rd_fifo_en  (rd_fifo_en),
        .rd_data_en  (rd_data_en),
        .byte4_en    (byte4_en),
        .byte4_busy  (byte4_busy),
        .byte4_data1 (byte4_data1),
        .byte4_data2 (byte4_data2),
        .byte4_data3 (byte4_data3),
        .byte4_data4 (byte4_data4),
        .byte4_valid (byte4_valid),
        .shift_dist  (shift_dist),
        .shift_en    (shift_en)
    );

    typedef struct {
        logic [31:0] d1, d2, d3, d4;
        logic        v, b;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mq[$];
    int          mpend = 0;
    int          checks = 0;
    int          failures = 0;
    bit          resp_on = 1'b1;
    bit          last_rd = 1'b0;
    int          widx = 0;
    string       stream = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";

    function automatic logic [7:0] mbyte(int i);
        return (i < mq.size()) ? mq[i] : 8'h00;
    endfunction

    function automatic logic [31:0] mwin(int n);
        return {mbyte(n - 1), mbyte(n), mbyte(n + 1), mbyte(n + 2)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit   exp_rd;
        int   s;
        int   newp;
        @(negedge clk);
        exp_rd = byte4_en && !fifo_empty && (mq.size() + 4 * mpend <= 8) && !rstN;
        chk("rd_fifo_en", {31'd0, rd_fifo_en}, {31'd0, exp_rd});
        if (rstN) begin
            mq.delete();
            mpend = 0;
        end else begin
            s = (shift_en && rd_data_en && mq.size() >= 7 && shift_dist != 3'd0) ? int'(shift_dist) : 0;
            repeat (s) void'(mq.pop_front());
            if (fifo_valid && mq.size() <= 12)
                for (int k = 3; k >= 0; k--) mq.push_back(fifo_data[8*k +: 8]);
            newp = mpend + (exp_rd ? 1 : 0) - ((fifo_valid && mpend > 0) ? 1 : 0);
            mpend = newp;
        end
        e.d1 = mwin(1);
        e.d2 = mwin(2);
        e.d3 = mwin(3);
        e.d4 = mwin(4);
        e.v  = (mq.size() >= 7);
        e.b  = byte4_en && !(mq.size() >= 7);
        sb.push_back(e);
        last_rd = exp_rd;
        @(posedge clk);
        #1;
        if (resp_on) begin
            fifo_valid = last_rd;
            if (last_rd) begin
                fifo_data = {stream[(4*widx) % 60], stream[(4*widx+1) % 60],
                             stream[(4*widx+2) % 60], stream[(4*widx+3) % 60]};
                widx++;
            end else begin
                fifo_data = $urandom();
            end
        end
        e = sb.pop_front();
        chk("byte4_data1", byte4_data1, e.d1);
        chk("byte4_data2", byte4_data2, e.d2);
        chk("byte4_data3", byte4_data3, e.d3);
        chk("byte4_data4", byte4_data4, e.d4);
        chk("byte4_valid", {31'd0, byte4_valid}, {31'd0, e.v});
        chk("byte4_busy",  {31'd0, byte4_busy},  {31'd0, e.b});
    endtask

    initial begin
        rstN = 1'b1; byte4_en = 1'b1; fifo_empty = 1'b0; rd_data_en = 1'b0;
        shift_en = 1'b0; shift_dist = 3'd0; fifo_valid = 1'b0; fifo_data = 32'h0;

        // reset state
        repeat (2) cycle();
        chk("rst_data1", byte4_data1, 32'h0);
        chk("rst_busy", {31'd0, byte4_busy}, 32'd1);

        // two requests, then stop fetching with fifo_empty
        rstN = 1'b0;
        cycle();
        cycle();
        fifo_empty = 1'b1;
        cycle();
        chk("fill_data1", byte4_data1, 32'h30313233);
        chk("fill_data2", byte4_data2, 32'h31323334);
        chk("fill_data4", byte4_data4, 32'h33343536);
        chk("fill_valid", {31'd0, byte4_valid}, 32'd1);
        chk("fill_busy",  {31'd0, byte4_busy},  32'd0);

        // shift blocked by rd_data_en = 0
        shift_en = 1'b1; shift_dist = 3'd1;
        cycle();
        chk("blocked_data1", byte4_data1, 32'h30313233);

        // shift by one
        rd_data_en = 1'b1;
        cycle();
        chk("shift1_data1", byte4_data1, 32'h31323334);

        // request resumes at cnt 7
        shift_en = 1'b0; fifo_empty = 1'b0;
        cycle();

        // shift 3 together with the arriving "89AB"
        shift_en = 1'b1; shift_dist = 3'd3;
        cycle();
        chk("shift3_data1", byte4_data1, 32'h34353637);
        chk("shift3_data4", byte4_data4, 32'h37383941);

        shift_en = 1'b0;
        repeat (4) cycle();

        // unsolicited words: accepted while it fits, dropped when full
        resp_on = 1'b0;
        fifo_valid = 1'b1; fifo_data = 32'hDEADBEEF;
        cycle();
        fifo_data = 32'hCAFEF00D;
        cycle();
        shift_en = 1'b1; shift_dist = 3'd7; fifo_data = 32'h11223344;
        cycle();

        // byte4_en = 0: no requests, shifting still works
        fifo_valid = 1'b0; byte4_en = 1'b0; shift_dist = 3'd5;
        cycle();
        shift_dist = 3'd1;
        cycle();
        shift_en = 1'b0;
        cycle();

        // fifo_empty blocks requests even at low fill
        byte4_en = 1'b1; fifo_empty = 1'b1;
        cycle();
        fifo_empty = 1'b0;
        cycle();

        // reset with data buffered and a read outstanding
        rstN = 1'b1;
        cycle();
        chk("midrst_data1", byte4_data1, 32'h0);
        chk("midrst_valid", {31'd0, byte4_valid}, 32'd0);
        rstN = 1'b0;
        fifo_valid = 1'b1; fifo_data = 32'h57585960;
        cycle();
        chk("postrst_data1", byte4_data1, 32'h57585960);
        fifo_valid = 1'b0; byte4_en = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
